// File: rtl/key_decoder_pkg.sv
// Shared definitions for the push-button decoder: per-channel FSM state
// encodings and helpers that derive tick counts from millisecond settings.
package key_decoder_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_PRESSED = 2'd1,
    KS_LONG    = 2'd2
  } key_state_e;

  localparam int NUM_KEYS = 2;

  function automatic int ms_to_ticks(input int ticks_per_ms, input int ms);
    return ticks_per_ms * ms;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold every value 0..n (never less than 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: two-flop synchroniser, stability debouncer and a
// short/long/auto-repeat classifier producing registered one-cycle pulses.
module key_channel
  import key_decoder_pkg::*;
#(
  parameter int DB_TICKS   = 20,
  parameter int LONG_TICKS = 100,
  parameter int REP_TICKS  = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic held,
  output logic press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DBW = cnt_width(DB_TICKS);
  localparam int HCW = cnt_width(max_int(LONG_TICKS, REP_TICKS));

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICKS - 1);
  localparam logic [HCW-1:0] LONG_LAST = HCW'(LONG_TICKS - 1);
  localparam logic [HCW-1:0] REP_LAST  = HCW'(REP_TICKS - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;   // debounced raw level, 1 = released
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  key_state_e      state_q, state_d;
  logic [HCW-1:0]  hc_q, hc_d;
  logic            held_q, held_d;
  logic            press_q, press_d;
  logic            long_q, long_d;
  logic            rep_q, rep_d;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = ~stable_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Classifier runs on the debounced level; a release always beats a
  // threshold reached in the same cycle.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    held_d  = ~stable_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (!stable_q) begin
          state_d = KS_PRESSED;
          hc_d    = '0;
        end
      end
      KS_PRESSED: begin
        if (stable_q) begin
          press_d = 1'b1;
          state_d = KS_IDLE;
          hc_d    = '0;
        end else if (hc_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = KS_LONG;
          hc_d    = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      KS_LONG: begin
        if (stable_q) begin
          state_d = KS_IDLE;
          hc_d    = '0;
        end else if (hc_q == REP_LAST) begin
          rep_d = 1'b1;
          hc_d  = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        state_d = KS_IDLE;
        hc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      db_cnt_q <= '0;
      state_q  <= KS_IDLE;
      hc_q     <= '0;
      held_q   <= 1'b0;
      press_q  <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      hc_q     <= hc_d;
      held_q   <= held_d;
      press_q  <= press_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
    end
  end

  assign held         = held_q;
  assign press        = press_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;

endmodule

// File: rtl/key_decoder.sv
// Two independent button channels for the Tang Nano boards, producing
// debounced levels and short/long/repeat command pulses.
module key_decoder
  import key_decoder_pkg::*;
#(
  parameter int TICKS_PER_MS = 24_000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONG_MS      = 1000,
  parameter int REPEAT_MS    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_n,
  output logic [1:0] held,
  output logic [1:0] press,
  output logic [1:0] long_press,
  output logic [1:0] repeat_pulse
);

  localparam int DB_TICKS   = ms_to_ticks(TICKS_PER_MS, DEBOUNCE_MS);
  localparam int LONG_TICKS = ms_to_ticks(TICKS_PER_MS, LONG_MS);
  localparam int REP_TICKS  = ms_to_ticks(TICKS_PER_MS, REPEAT_MS);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
      key_channel #(
        .DB_TICKS  (DB_TICKS),
        .LONG_TICKS(LONG_TICKS),
        .REP_TICKS (REP_TICKS)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n[gi]),
        .held        (held[gi]),
        .press       (press[gi]),
        .long_press  (long_press[gi]),
        .repeat_pulse(repeat_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: expected output events are queued as
// buttons are driven and matched against events seen on the outputs.
module tb_key_decoder;

  localparam int DB   = 20;
  localparam int LONG = 100;
  localparam int REP  = 40;
  localparam int L    = DB + 3;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_PRESS = 2;
  localparam int K_LONG = 3;
  localparam int K_REP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] held, press, long_press, repeat_pulse;
  logic [1:0] prev_held = 2'b00;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  ev_t exp_q[$];

  key_decoder #(
    .TICKS_PER_MS(10),
    .DEBOUNCE_MS (2),
    .LONG_MS     (10),
    .REPEAT_MS   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .held        (held),
    .press       (press),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      K_RISE:  return "held_rise";
      K_FALL:  return "held_fall";
      K_PRESS: return "press";
      K_LONG:  return "long_press";
      default: return "repeat";
    endcase
  endfunction

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c;
    e.ch = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Expected events for a clean raw hold of d cycles starting at cycle t0.
  task automatic push_hold(input int ch, input int t0, input int d);
    int h;
    h = t0 + L;
    push_ev(h, ch, K_RISE);
    if (d <= LONG) begin
      push_ev(h + d, ch, K_PRESS);
    end else begin
      push_ev(h + LONG, ch, K_LONG);
      for (int k = 1; LONG + k * REP < d; k++) push_ev(h + LONG + k * REP, ch, K_REP);
    end
    push_ev(h + d, ch, K_FALL);
  endtask

  task automatic observe(input int ch, input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].ch == ch && exp_q[i].kind == kind) idx = i;
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL unexpected_%s ch%0d: observed at cycle %0d, required none", kname(kind), ch, cyc);
    end else begin
      if (exp_q[idx].cyc !== cyc) begin
        miscompares++;
        $display("FAIL %s_timing ch%0d: observed cycle %0d, required cycle %0d",
                 kname(kind), ch, cyc, exp_q[idx].cyc);
      end else begin
        $display("ok  %s ch%0d at cycle %0d", kname(kind), ch, cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_held <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (held[ch] && !prev_held[ch]) observe(ch, K_RISE);
        if (!held[ch] && prev_held[ch]) observe(ch, K_FALL);
        if (press[ch]) observe(ch, K_PRESS);
        if (long_press[ch]) observe(ch, K_LONG);
        if (repeat_pulse[ch]) observe(ch, K_REP);
      end
      prev_held <= held;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: observed %0d expected events absent, required 0 (first %s ch%0d cycle %0d)",
               name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].ch, exp_q[0].cyc);
    end else begin
      $display("ok  %s all expected events seen", name);
    end
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({held, press, long_press, repeat_pulse} !== 8'h00) begin
      miscompares++;
      $display("FAIL %s: observed held=%b press=%b long=%b repeat=%b, required all 0",
               name, held, press, long_press, repeat_pulse);
    end else begin
      $display("ok  %s outputs zero", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b0;
    wait_until(cyc + 30);
    check_drained("reset_idle");
  endtask

  task automatic test_short_press();
    int t0;
    t0 = cyc;
    push_hold(0, t0, 60);
    btn_n[0] = 1'b0;
    wait_until(t0 + 60);
    btn_n[0] = 1'b1;
    wait_until(t0 + 60 + L + 20);
    check_drained("short_press");
  endtask

  task automatic test_bounce();
    int tf;
    for (int i = 0; i < 20; i++) begin
      btn_n[1] = ~btn_n[1];
      wait_until(cyc + 5);
    end
    tf = cyc;
    push_hold(1, tf, 60);
    btn_n[1] = 1'b0;
    wait_until(tf + 60);
    btn_n[1] = 1'b1;
    wait_until(tf + 60 + L + 20);
    check_drained("bounce");
  endtask

  task automatic test_long_repeat();
    int t0;
    t0 = cyc;
    push_hold(0, t0, 250);
    btn_n[0] = 1'b0;
    wait_until(t0 + 250);
    btn_n[0] = 1'b1;
    wait_until(t0 + 250 + L + 60);
    check_drained("long_repeat");
  endtask

  task automatic test_release_on_threshold();
    int t0;
    t0 = cyc;
    push_hold(0, t0, LONG);
    btn_n[0] = 1'b0;
    wait_until(t0 + LONG);
    btn_n[0] = 1'b1;
    wait_until(t0 + LONG + L + 30);
    check_drained("release_on_threshold");
  endtask

  task automatic test_reset_mid_hold();
    int t0, tr, trel;
    t0 = cyc;
    push_ev(t0 + L, 0, K_RISE);
    push_ev(t0 + L + LONG, 0, K_LONG);
    btn_n[0] = 1'b0;
    wait_until(t0 + L + 120);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_async");
    check_drained("reset_pre_hold");
    wait_until(cyc + 3);
    rst = 1'b0;
    tr = cyc;
    push_ev(tr + L, 0, K_RISE);
    push_ev(tr + L + LONG, 0, K_LONG);
    wait_until(tr + 130);
    btn_n[0] = 1'b1;
    trel = cyc;
    push_ev(trel + L, 0, K_FALL);
    wait_until(trel + L + 40);
    check_drained("reset_mid_hold");
  endtask

  task automatic test_independence();
    int t0, t1;
    t0 = cyc;
    push_hold(0, t0, 150);
    btn_n[0] = 1'b0;
    wait_until(t0 + 7);
    t1 = cyc;
    push_hold(1, t1, 150);
    btn_n[1] = 1'b0;
    wait_until(t0 + 150);
    btn_n[0] = 1'b1;
    wait_until(t1 + 150);
    btn_n[1] = 1'b1;
    wait_until(t1 + 150 + L + 40);
    check_drained("independence");
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_bounce();
    test_long_repeat();
    test_release_on_threshold();
    test_reset_mid_hold();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
